// File: rtl/ctrl_pkg.sv
// Shared opcode/funct encodings, ALU codes and the control bundles that flow
// down the pipelined MIPS control path.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam int unsigned ALU_CODE_W = 3;
  localparam int unsigned CNT_W      = 4;

  localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL = 3'b011;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL = 3'b100;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

  // Controls consumed in write-back; carried through every memory stage.
  typedef struct packed {
    logic we_reg;
    logic dm2reg;
    logic link;
    logic sfmux_high;
    logic sf2reg;
  } w_ctrl_t;

  // Full bundle loaded into the E stage register.
  typedef struct packed {
    logic                  reg_dst;
    logic                  alu_src;
    logic                  shmux;
    logic                  mult_enable;
    logic                  we_dm;
    logic [ALU_CODE_W-1:0] alu_op;
    w_ctrl_t               w;
  } e_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decode of opcode/funct into the control bundle,
// D-stage branch/jump strobes and the HI/LO interlock classifiers.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output e_ctrl_t    ctrl,
  output logic       branch,
  output logic       jump,
  output logic       jal,
  output logic       jr,
  output logic       illegal,
  output logic       mfhilo,
  output logic       multu
);

  always_comb begin
    ctrl    = '0;
    branch  = 1'b0;
    jump    = 1'b0;
    jal     = 1'b0;
    jr      = 1'b0;
    illegal = 1'b0;
    mfhilo  = 1'b0;
    multu   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst  = 1'b1;
        ctrl.w.we_reg = 1'b1;
        unique case (funct)
          FN_ADD: ctrl.alu_op = ALU_ADD;
          FN_SUB: ctrl.alu_op = ALU_SUB;
          FN_AND: ctrl.alu_op = ALU_AND;
          FN_OR:  ctrl.alu_op = ALU_OR;
          FN_SLT: ctrl.alu_op = ALU_SLT;
          FN_SLL: begin
            ctrl.alu_op = ALU_SLL;
            ctrl.shmux  = 1'b1;
          end
          FN_SRL: begin
            ctrl.alu_op = ALU_SRL;
            ctrl.shmux  = 1'b1;
          end
          FN_JR: begin
            ctrl = '0;
            jr   = 1'b1;
          end
          FN_MULTU: begin
            ctrl             = '0;
            ctrl.mult_enable = 1'b1;
            multu            = 1'b1;
          end
          FN_MFHI: begin
            ctrl.w.sf2reg     = 1'b1;
            ctrl.w.sfmux_high = 1'b1;
            mfhilo            = 1'b1;
          end
          FN_MFLO: begin
            ctrl.w.sf2reg = 1'b1;
            mfhilo        = 1'b1;
          end
          default: begin
            ctrl    = '0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        ctrl.w.we_reg = 1'b1;
        ctrl.w.dm2reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        ctrl.we_dm   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        branch      = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        ctrl.w.we_reg = 1'b1;
      end
      OP_J: jump = 1'b1;
      OP_JAL: begin
        // Link write travels to W like any other register write.
        jump          = 1'b1;
        jal           = 1'b1;
        ctrl.w.we_reg = 1'b1;
        ctrl.w.link   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_hz.sv
// Pipelined MIPS control unit: D decode, E register with bubble/freeze,
// configurable memory-stage chain, W register and multiplier busy tracking.
module ctrl_pipe_hz
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned MULT_LAT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  stall_in,
  input  logic                  flush_e,
  input  logic                  freeze,
  output logic                  branch_d,
  output logic                  jump_d,
  output logic                  jal_d,
  output logic                  jr_d,
  output logic                  illegal_d,
  output logic                  stall_d,
  output logic                  reg_dst_e,
  output logic                  alu_src_e,
  output logic                  shmux_e,
  output logic                  mult_enable_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic                  we_dm_m,
  output logic                  we_reg_w,
  output logic                  dm2reg_w,
  output logic                  link_w,
  output logic                  sfmux_high_w,
  output logic                  sf2reg_w,
  output logic                  mult_busy,
  output logic                  mult_done
);

  e_ctrl_t          dec;
  e_ctrl_t          e_q;
  logic             we_dm_q;
  w_ctrl_t          m_q [MEM_STAGES];
  w_ctrl_t          w_q;
  logic [CNT_W-1:0] cnt;
  logic             mfhilo_d;
  logic             multu_d;
  logic             bubble;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .ctrl    (dec),
    .branch  (branch_d),
    .jump    (jump_d),
    .jal     (jal_d),
    .jr      (jr_d),
    .illegal (illegal_d),
    .mfhilo  (mfhilo_d),
    .multu   (multu_d)
  );

  // HI/LO interlock: wait out a running multiply, or one just entering E.
  assign stall_d = (mult_busy & (mfhilo_d | multu_d)) | (mfhilo_d & e_q.mult_enable);
  assign bubble  = flush_e | stall_in | stall_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
    end else if (!freeze) begin
      e_q <= bubble ? e_ctrl_t'('0) : dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_dm_q <= 1'b0;
      m_q[0]  <= '0;
    end else if (!freeze) begin
      we_dm_q <= e_q.we_dm;
      m_q[0]  <= e_q.w;
    end
  end

  for (genvar i = 1; i < int'(MEM_STAGES); i++) begin : g_mem
    always_ff @(posedge clk) begin
      if (rst) begin
        m_q[i] <= '0;
      end else if (!freeze) begin
        m_q[i] <= m_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
    end else if (!freeze) begin
      w_q <= m_q[MEM_STAGES-1];
    end
  end

  // A multu leaving E (re)loads the occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (e_q.mult_enable) begin
        cnt <= CNT_W'(MULT_LAT);
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign mult_busy = (cnt != '0);
  assign mult_done = (cnt == CNT_W'(1)) & ~freeze;

  assign reg_dst_e     = e_q.reg_dst;
  assign alu_src_e     = e_q.alu_src;
  assign shmux_e       = e_q.shmux;
  assign mult_enable_e = e_q.mult_enable;
  assign alu_ctrl_e    = ALU_CTRL_W'(e_q.alu_op);
  assign we_dm_m       = we_dm_q;
  assign we_reg_w      = w_q.we_reg;
  assign dm2reg_w      = w_q.dm2reg;
  assign link_w        = w_q.link;
  assign sfmux_high_w  = w_q.sfmux_high;
  assign sf2reg_w      = w_q.sf2reg;

endmodule

// File: tb/tb_ctrl_pipe_hz.sv
// Directed bench for ctrl_pipe_hz with default parameters (MEM_STAGES=1, MULT_LAT=4).
module tb_ctrl_pipe_hz;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       stall_in;
  logic       flush_e;
  logic       freeze;
  logic       branch_d, jump_d, jal_d, jr_d, illegal_d, stall_d;
  logic       reg_dst_e, alu_src_e, shmux_e, mult_enable_e;
  logic [3:0] alu_ctrl_e;
  logic       we_dm_m, we_reg_w, dm2reg_w, link_w, sfmux_high_w, sf2reg_w;
  logic       mult_busy, mult_done;

  int checks = 0;
  int errors = 0;

  ctrl_pipe_hz #(.ALU_CTRL_W(4), .MEM_STAGES(1), .MULT_LAT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct         (funct),
    .stall_in      (stall_in),
    .flush_e       (flush_e),
    .freeze        (freeze),
    .branch_d      (branch_d),
    .jump_d        (jump_d),
    .jal_d         (jal_d),
    .jr_d          (jr_d),
    .illegal_d     (illegal_d),
    .stall_d       (stall_d),
    .reg_dst_e     (reg_dst_e),
    .alu_src_e     (alu_src_e),
    .shmux_e       (shmux_e),
    .mult_enable_e (mult_enable_e),
    .alu_ctrl_e    (alu_ctrl_e),
    .we_dm_m       (we_dm_m),
    .we_reg_w      (we_reg_w),
    .dm2reg_w      (dm2reg_w),
    .link_w        (link_w),
    .sfmux_high_w  (sfmux_high_w),
    .sf2reg_w      (sf2reg_w),
    .mult_busy     (mult_busy),
    .mult_done     (mult_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    #1;
  endtask

  // {reg_dst, alu_src, shmux, mult_en, alu_ctrl[3:0]}
  function automatic logic [7:0] e_vec();
    return {reg_dst_e, alu_src_e, shmux_e, mult_enable_e, alu_ctrl_e};
  endfunction

  // {we_reg, dm2reg, link, sfmux_high, sf2reg}
  function automatic logic [4:0] w_vec();
    return {we_reg_w, dm2reg_w, link_w, sfmux_high_w, sf2reg_w};
  endfunction

  logic [4:0] busy_seq;
  logic [4:0] done_seq;

  initial begin
    rst = 1'b1; opcode = 6'b0; funct = 6'b0;
    stall_in = 1'b0; flush_e = 1'b0; freeze = 1'b0;
    step(); step();
    check("reset_e", 32'(e_vec()), 32'h0);
    check("reset_w", 32'(w_vec()), 32'h0);
    check("reset_mult", 32'({we_dm_m, mult_busy, mult_done}), 32'h0);

    // add: E controls after one edge, W write after three
    rst = 1'b0;
    drive(6'b000000, 6'b100000);
    check("add_illegal", 32'(illegal_d), 32'h0);
    step();
    check("add_e", 32'(e_vec()), 32'h82);
    stall_in = 1'b1;
    step();
    check("add_w_early", 32'(w_vec()), 32'h0);
    check("bubble_e", 32'(e_vec()), 32'h0);
    step();
    check("add_w", 32'(w_vec()), 32'h10);

    // lw killed by flush_e never writes back
    stall_in = 1'b0; flush_e = 1'b1;
    drive(6'b100011, 6'b000000);
    step();
    check("lw_flush_e", 32'(e_vec()), 32'h0);
    flush_e = 1'b0; stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lw_flush_w", 32'(w_vec()), 32'h0);
    end

    // lw normal
    stall_in = 1'b0;
    drive(6'b100011, 6'b000000);
    step();
    check("lw_e", 32'(e_vec()), 32'h42);
    stall_in = 1'b1;
    step(); step();
    check("lw_w", 32'(w_vec()), 32'h18);

    // sw: memory write in M1 only
    stall_in = 1'b0;
    drive(6'b101011, 6'b000000);
    step();
    check("sw_e", 32'(e_vec()), 32'h42);
    stall_in = 1'b1;
    step();
    check("sw_m", 32'(we_dm_m), 32'h1);
    step();
    check("sw_m_clr", 32'(we_dm_m), 32'h0);
    check("sw_w", 32'(w_vec()), 32'h0);

    // jal: link write reaches W three edges later
    stall_in = 1'b0;
    drive(6'b000011, 6'b000000);
    check("jal_d", 32'({jal_d, branch_d, jr_d}), 32'h4);
    step();
    stall_in = 1'b1;
    step(); step();
    check("jal_w", 32'(w_vec()), 32'h14);

    // beq / jr / sll / srl / addi decode
    stall_in = 1'b0;
    drive(6'b000100, 6'b000000);
    check("beq_d", 32'({branch_d, jump_d, jr_d}), 32'h4);
    step();
    check("beq_e", 32'(e_vec()), 32'h06);
    drive(6'b000000, 6'b001000);
    check("jr_d", 32'({jr_d, branch_d, illegal_d}), 32'h4);
    step();
    check("jr_e", 32'(e_vec()), 32'h0);
    drive(6'b000000, 6'b000000);
    step();
    check("sll_e", 32'(e_vec()), 32'hA3);
    drive(6'b000000, 6'b000010);
    step();
    check("srl_e", 32'(e_vec()), 32'hA4);
    drive(6'b000000, 6'b101010);
    step();
    check("slt_e", 32'(e_vec()), 32'h87);
    drive(6'b001000, 6'b000000);
    step();
    check("addi_e", 32'(e_vec()), 32'h42);

    // illegal opcode and funct become bubbles
    drive(6'b111111, 6'b000000);
    check("illegal_op", 32'({illegal_d, stall_d}), 32'h2);
    step();
    check("illegal_op_e", 32'(e_vec()), 32'h0);
    drive(6'b000000, 6'b111111);
    check("illegal_fn", 32'(illegal_d), 32'h1);
    step();
    check("illegal_fn_e", 32'(e_vec()), 32'h0);
    stall_in = 1'b1;
    step(); step();
    check("illegal_w", 32'(w_vec()), 32'h0);

    // multu then mflo: interlock until counter drains
    stall_in = 1'b0;
    drive(6'b000000, 6'b011001);
    check("multu_nostall", 32'(stall_d), 32'h0);
    step();
    check("multu_e", 32'(e_vec()), 32'h10);
    drive(6'b000000, 6'b010010);
    check("mflo_stall_e", 32'({stall_d, mult_busy}), 32'h2);
    busy_seq = 5'b01111;
    done_seq = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mul_busy", 32'(mult_busy), 32'(busy_seq[i]));
      check("mul_done", 32'(mult_done), 32'(done_seq[i]));
      check("mul_stall", 32'(stall_d), 32'(busy_seq[i]));
    end
    step();
    check("mflo_e", 32'(e_vec()), 32'h80);
    stall_in = 1'b1;
    step(); step();
    check("mflo_w", 32'(w_vec()), 32'h11);

    // freeze mid-multiply, including on the last busy cycle
    stall_in = 1'b0;
    drive(6'b000000, 6'b011001);
    step();
    drive(6'b000000, 6'b010000);
    step(); step(); step();
    check("frz_pre_done", 32'({mult_busy, mult_done}), 32'h2);
    step();
    check("frz_done_pre", 32'({mult_busy, mult_done}), 32'h3);
    freeze = 1'b1;
    #1;
    check("frz_done_mask", 32'({mult_busy, mult_done, stall_d}), 32'h5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_hold", 32'({mult_busy, mult_done, stall_d}), 32'h5);
    end
    freeze = 1'b0;
    #1;
    check("frz_release", 32'(mult_done), 32'h1);
    step();
    check("frz_drain", 32'({mult_busy, mult_done, stall_d}), 32'h0);
    step();
    check("mfhi_e", 32'(e_vec()), 32'h80);
    stall_in = 1'b1;
    step(); step();
    check("mfhi_w", 32'(w_vec()), 32'h13);

    // freeze holds the pipeline registers
    stall_in = 1'b0;
    drive(6'b000000, 6'b100000);
    step();
    freeze = 1'b1;
    drive(6'b101011, 6'b000000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_e_hold", 32'(e_vec()), 32'h82);
      check("frz_w_hold", 32'({w_vec(), we_dm_m}), 32'h0);
    end
    freeze = 1'b0; stall_in = 1'b1;
    step();
    check("unfrz_e", 32'(e_vec()), 32'h0);
    check("unfrz_w_early", 32'(w_vec()), 32'h0);
    step();
    check("unfrz_w", 32'(w_vec()), 32'h10);

    // reset during a multiply clears everything, no done pulse after
    stall_in = 1'b0;
    drive(6'b000000, 6'b011001);
    step();
    drive(6'b000000, 6'b010010);
    step(); step();
    check("rstmul_busy", 32'(mult_busy), 32'h1);
    rst = 1'b1;
    step();
    check("rstmul_clr", 32'({mult_busy, mult_done, mult_enable_e}), 32'h0);
    check("rstmul_e", 32'(e_vec()), 32'h0);
    rst = 1'b0; stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstmul_idle", 32'({mult_busy, mult_done}), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
